// File: rtl/i2c_send.sv
// I2C master byte transmitter: START, MSB-first data, ACK slot, STOP, with HOLD between bytes.
// Optional macro I2C_IDLE_STOP_EN: release the bus with STOP after HOLD_TIMEOUT idle bit periods in HOLD.
module i2c_send #(
  parameter int QDIV         = 25,
  parameter int HOLD_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_ready,
  input  logic [7:0] pre_data,
  output logic       out_flag,
  output logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic       byte_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam int QW = $clog2(QDIV);

  logic [2:0]    state;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bitcnt;
  logic [7:0]    sreg;
  logic          nack;
  logic          sda_o;

  logic q_last, bit_end, bd_pre;
  assign q_last  = (qcnt == QW'(QDIV - 1));
  assign bit_end = q_last && (phase == 2'd3);
  // byte_done is registered, so arm it one clk ahead to land on the last clk of Q3
  assign bd_pre  = (phase == 2'd3) && (qcnt == QW'(QDIV - 2));

`ifdef I2C_IDLE_STOP_EN
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  logic [HW-1:0] hold_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      qcnt      <= '0;
      phase     <= 2'd0;
      bitcnt    <= 3'd0;
      sreg      <= 8'h00;
      nack      <= 1'b0;
      out_flag  <= 1'b0;
      byte_done <= 1'b0;
`ifdef I2C_IDLE_STOP_EN
      hold_cnt  <= '0;
`endif
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pre_ready) begin
            sreg  <= pre_data;
            state <= START;
            qcnt  <= '0;
            phase <= 2'd0;
          end
        end
        HOLD: begin
          if (pre_ready) begin
            sreg   <= pre_data;
            state  <= DATA;
            qcnt   <= '0;
            phase  <= 2'd0;
            bitcnt <= 3'd0;
`ifdef I2C_IDLE_STOP_EN
            hold_cnt <= '0;
          end else begin
            qcnt  <= q_last ? '0 : qcnt + 1'b1;
            if (q_last) phase <= phase + 2'd1;
            if (bit_end) begin
              if (hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
                hold_cnt <= '0;
                state    <= STOP;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
`endif
          end
        end
        default: begin
          qcnt <= q_last ? '0 : qcnt + 1'b1;
          if (q_last) phase <= phase + 2'd1;
          case (state)
            START: if (bit_end) state <= DATA;
            DATA: begin
              if (bit_end) begin
                sreg   <= {sreg[6:0], 1'b0};
                bitcnt <= bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                  state    <= ACK;
                  out_flag <= 1'b1;
                end
              end
            end
            ACK: begin
              if (q_last && phase == 2'd2) nack <= i2c_sda;
              if (bd_pre) byte_done <= 1'b1;
              if (bit_end) begin
                out_flag <= 1'b0;
                state    <= nack ? STOP : HOLD;
              end
            end
            STOP:    if (bit_end) state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    i2c_scl = 1'b1;
    sda_o   = 1'b1;
    case (state)
      START: begin
        i2c_scl = (phase != 2'd3);
        sda_o   = (phase < 2'd2);
      end
      DATA: begin
        i2c_scl = phase[1];
        sda_o   = sreg[7];
      end
      ACK:  i2c_scl = phase[1];
      HOLD: begin
        i2c_scl = 1'b0;
        sda_o   = 1'b0;
      end
      STOP: begin
        i2c_scl = phase[1];
        sda_o   = (phase == 2'd3);
      end
      default: ;
    endcase
  end

  // SDA is released for the slave only while the ACK slot is flagged
  assign i2c_sda = out_flag ? 1'bz : sda_o;

endmodule

// File: tb/tb_i2c_send.sv
// Directed bench for i2c_send at QDIV=2 (bit period 8 clk); checks bus levels per phase.
module tb_i2c_send;
  logic       clk;
  logic       rst_n;
  logic       pre_ready;
  logic [7:0] pre_data;
  logic       out_flag, i2c_scl, byte_done;
  logic       slave_bit;
  wire        i2c_sda;

  int n_cmp = 0;
  int n_err = 0;
  int bd_cnt = 0;

  i2c_send #(.QDIV(2), .HOLD_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .pre_ready(pre_ready), .pre_data(pre_data),
    .out_flag(out_flag), .i2c_scl(i2c_scl), .i2c_sda(i2c_sda), .byte_done(byte_done)
  );

  assign i2c_sda = out_flag ? slave_bit : 1'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (byte_done === 1'b1) bd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one byte: pre_ready high for exactly one rising edge
  task automatic offer(input logic [7:0] d);
    @(posedge clk); #1;
    pre_ready = 1'b1;
    pre_data  = d;
    @(posedge clk); #1;
    pre_ready = 1'b0;
  endtask

  // Walk one byte from the accepting edge to the last clk of its ACK bit
  task automatic walk(input logic [7:0] d, input bit with_start, input logic slave);
    int nb;
    slave_bit = slave;
    nb = with_start ? 8 : 0;
    for (int c = 0; c < nb + 72; c++) begin
      @(negedge clk);
      if (with_start && c == 1) begin chk("start_q0_scl", i2c_scl, 1); chk("start_q0_sda", i2c_sda, 1); end
      if (with_start && c == 5) begin chk("start_q2_scl", i2c_scl, 1); chk("start_q2_sda", i2c_sda, 0); end
      if (with_start && c == 7) begin chk("start_q3_scl", i2c_scl, 0); chk("start_q3_sda", i2c_sda, 0); end
      if (c >= nb && c < nb + 64) begin
        int o, b;
        o = (c - nb) % 8;
        b = (c - nb) / 8;
        if (o == 0) chk("data_q0_scl", i2c_scl, 0);
        if (o == 3) chk("data_flag", out_flag, 0);
        if (o == 5) begin
          chk("data_q2_scl", i2c_scl, 1);
          chk("data_bit", i2c_sda, d[7-b]);
        end
      end
      if (c >= nb + 64) begin
        int o;
        o = c - nb - 64;
        if (o == 0) chk("ack_flag_first", out_flag, 1);
        if (o == 5) chk("ack_scl_high", i2c_scl, 1);
        if (o == 6) chk("ack_done_early", byte_done, 0);
        if (o == 7) begin chk("ack_flag_last", out_flag, 1); chk("ack_done", byte_done, 1); end
      end
    end
  endtask

  task automatic hold_then(input logic [7:0] d);
    @(posedge clk); #1;
    chk("hold_scl", i2c_scl, 0);
    chk("hold_sda", i2c_sda, 0);
    chk("hold_flag", out_flag, 0);
    chk("hold_done", byte_done, 0);
    pre_ready = 1'b1;
    pre_data  = d;
    @(posedge clk); #1;
    pre_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pre_ready = 1'b1; pre_data = 8'hF0; slave_bit = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_scl", i2c_scl, 1);
    chk("rst_sda", i2c_sda, 1);
    chk("rst_flag", out_flag, 0);
    chk("rst_done", byte_done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pre_ready = 1'b0;
    walk(8'hF0, 1, 0);

    // back-to-back stream: no repeated START, last byte NACKed
    hold_then(8'hF1); walk(8'hF1, 0, 0);
    hold_then(8'hF2); walk(8'hF2, 0, 0);
    hold_then(8'hF3); walk(8'hF3, 0, 0);
    hold_then(8'hF4); walk(8'hF4, 0, 1);
    repeat (2) @(negedge clk);
    chk("stop_q0_scl", i2c_scl, 0); chk("stop_q0_sda", i2c_sda, 0);
    repeat (4) @(negedge clk);
    chk("stop_q2_scl", i2c_scl, 1); chk("stop_q2_sda", i2c_sda, 0);
    repeat (2) @(negedge clk);
    chk("stop_q3_scl", i2c_scl, 1); chk("stop_q3_sda", i2c_sda, 1);
    @(negedge clk);
    chk("idle_scl", i2c_scl, 1); chk("idle_sda", i2c_sda, 1); chk("idle_flag", out_flag, 0);
    chk("byte_done_count", bd_cnt, 5);

    // reset in the middle of DATA (bit 1 of 0x35 is 0, SCL low)
    offer(8'h35);
    repeat (20) @(negedge clk);
    chk("pre_rst_scl", i2c_scl, 0);
    chk("pre_rst_sda", i2c_sda, 0);
    rst_n = 1'b0; #1;
    chk("mid_rst_scl", i2c_scl, 1);
    chk("mid_rst_sda", i2c_sda, 1);
    chk("mid_rst_flag", out_flag, 0);
    chk("mid_rst_done", byte_done, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    offer(8'hA5);
    walk(8'hA5, 1, 0);

    // idle in HOLD after an ACKed byte
    repeat (21) @(negedge clk);
    chk("hold_idle_scl", i2c_scl, 0);
`ifdef I2C_IDLE_STOP_EN
    repeat (47) @(negedge clk);
    chk("to_stop_q1_scl", i2c_scl, 0);
    @(negedge clk);
    chk("to_stop_q2_scl", i2c_scl, 1); chk("to_stop_q2_sda", i2c_sda, 0);
    repeat (2) @(negedge clk);
    chk("to_stop_q3_sda", i2c_sda, 1);
    repeat (2) @(negedge clk);
    chk("to_idle_scl", i2c_scl, 1); chk("to_idle_sda", i2c_sda, 1);
`else
    repeat (48) @(negedge clk);
    chk("hold_stay_scl", i2c_scl, 0); chk("hold_stay_sda", i2c_sda, 0);
    repeat (100) @(negedge clk);
    chk("hold_long_scl", i2c_scl, 0); chk("hold_long_flag", out_flag, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_send.md
Name: i2c_send

Overview:
- I2C master byte transmitter. Accepts bytes on a ready/data strobe and serialises them MSB-first on SCL/SDA with START, a per-byte ACK slot and STOP.
- Sits between a byte producer (register sequencer or config ROM) and the I2C pins.
- Reports each completed byte with a one-cycle `byte_done` pulse.
- Flags the ACK slot on `out_flag`, during which SDA is released.

Parameters:
- QDIV, 25: clk cycles per quarter SCL bit period. Bit period = 4*QDIV clk; 50 MHz clk gives 500 kHz SCL. Legal range >= 2.
- HOLD_TIMEOUT, 8: bit periods to wait in HOLD for the next byte before issuing STOP. Used only with I2C_IDLE_STOP_EN.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- pre_ready  input  1  byte-available strobe; sampled in IDLE and HOLD
- pre_data  input  8  byte to send; captured when pre_ready is accepted
- out_flag  output  1  high during the ACK bit; SDA released (Z), slave drives it
- i2c_scl  output  1  I2C clock, push-pull
- i2c_sda  inout  1  I2C data; driven 0/1 when out_flag=0, Z when out_flag=1
- byte_done  output  1  one-clk pulse at end of each ACK bit

Behaviour:
- Reset (async): state=IDLE, i2c_scl=1, SDA driven 1, out_flag=0, byte_done=0, quarter counter=0, bit counter=0.
- Timing base:
  - Quarter counter counts 0..QDIV-1; each wrap advances a phase Q0..Q3.
  - Bit phases: Q0,Q1 SCL=0 (SDA changes at Q0 entry); Q2,Q3 SCL=1.
- State IDLE (SCL=1, SDA=1): if pre_ready=1, capture pre_data into a shift register, go to START.
- State START: Q0-Q1 SDA=1/SCL=1; Q2 SDA=0/SCL=1; Q3 SDA=0/SCL=0; then DATA.
- State DATA: 8 bits, MSB first.
  - Shift register bit 7 is placed on SDA at Q0; register shifts left at end of Q3.
  - Bit counter 0..7; after bit 7 go to ACK.
- State ACK:
  - out_flag=1 and SDA=Z for the whole bit.
  - SDA sampled at the last clk of Q2 into internal `nack`.
  - byte_done=1 for exactly one clk on the last clk of Q3; out_flag drops the following clk.
  - Next state: STOP if nack=1, else HOLD.
- State HOLD (SCL=0, SDA=0):
  - If pre_ready=1, capture pre_data, restart phase at Q0, go to DATA (no repeated START).
  - pre_ready asserted in the clk right after byte_done must be accepted.
- State STOP: Q0-Q1 SCL=0/SDA=0; Q2 SCL=1/SDA=0; Q3 SCL=1/SDA=1; then IDLE.
- pre_ready is ignored in START/DATA/ACK/STOP. pre_data is only read at capture.
- Reset mid-transfer returns immediately to IDLE levels. No STOP is generated.
- out_flag and byte_done are registered outputs.

Optional Feature:
- I2C_IDLE_STOP_EN:
  - Defined: HOLD counts bit periods; if no pre_ready within HOLD_TIMEOUT bit periods, go to STOP then IDLE.
  - Undefined: HOLD waits indefinitely; the bus is released only by NACK or reset.

Test Plan:
- Reset with pre_ready=1, pre_data=0xF0, QDIV=2 -> START (SDA falls while SCL=1), then SDA bits 1,1,1,1,0,0,0,0 valid across each SCL high phase. out_flag=1 for the 9th bit. byte_done pulses 1 clk; bit period = 8 clk.
- Slave drives SDA=0 during ACK; producer sends 0xF1 with pre_ready the clk after byte_done -> no START, next byte starts immediately, SCL stays low in HOLD.
- Stream 0xF0..0xF4; slave ACKs data <= 0xF3 and NACKs 0xF4 -> 5 byte_done pulses, then STOP (SDA rises while SCL=1), then IDLE with SCL=1, SDA=1.
- Check out_flag=1 only during ACK bits -> the bench's SDA drive never overlaps the DUT's drive (no X on SDA outside ACK).
- Assert rst_n low mid-DATA -> SCL=1, SDA=1, out_flag=0, byte_done=0 immediately; next pre_ready starts a fresh START.
- With I2C_IDLE_STOP_EN, HOLD_TIMEOUT=8: after an ACKed byte, hold pre_ready=0 -> STOP begins after 8 bit periods (64 clk at QDIV=2). Without the macro, SCL stays 0 indefinitely.
